// File: rtl/mips_multicycle_control.sv
// Multicycle control FSM for the MIPS core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module mips_multicycle_control #(
  parameter int MEM_WAIT_MAX  = 15,
  parameter bit ENABLE_JAL_JR = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        branch_gtz,
  output logic        instr_done,
  output logic        illegal,
  output logic        timeout,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state;
  state_t     dec_next;
  logic       dec_bad;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       wait_expired;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];
  assign state_out         = state;

  assign in_wait      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // A completing access in the same cycle beats the timeout.
  assign wait_expired = in_wait && !mem_ready && (wait_cnt == WAIT_MAX);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_next = S_FETCH;
    dec_bad  = 1'b0;
    case (opcode)
      6'b100011, 6'b100000, 6'b100001,
      6'b101011, 6'b101000, 6'b101001: dec_next = S_MEMADR;
      6'b000000: begin
        if (funct == 6'b001000) begin
          if (ENABLE_JAL_JR) dec_next = S_JR;
          else               dec_bad  = 1'b1;
        end else begin
          dec_next = S_EXEC_R;
        end
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: dec_next = S_EXEC_I;
      6'b000100, 6'b000101, 6'b000111:            dec_next = S_BRANCH;
      6'b000010:                                  dec_next = S_JUMP;
      6'b000011: begin
        if (ENABLE_JAL_JR) dec_next = S_JAL;
        else               dec_bad  = 1'b1;
      end
      default: dec_bad = 1'b1;
    endcase
    if (dec_bad) dec_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= (in_wait && !mem_ready && !wait_expired) ? wait_cnt + 8'd1 : 8'd0;
      if (wait_expired) begin
        state   <= S_TRAP;
        timeout <= 1'b1;
      end else begin
        case (state)
          S_FETCH:  if (mem_ready) state <= S_DECODE;
          S_DECODE: begin
            state <= dec_next;
            if (dec_bad && ILLEGAL_TRAP) illegal <= 1'b1;
          end
          // Stores are the 101xxx opcodes, loads 100xxx.
          S_MEMADR: state <= opcode[3] ? S_MEMWR : S_MEMRD;
          S_MEMRD:  if (mem_ready) state <= S_MEMWB;
          S_MEMWR:  if (mem_ready) state <= S_FETCH;
          S_EXEC_R: state <= S_RWB;
          S_EXEC_I: state <= S_IWB;
          S_TRAP:   state <= S_TRAP;
          default:  state <= S_FETCH;
        endcase
      end
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    branch_gtz = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        // Gated by rst so a held-ready memory cannot load IR/PC during reset.
        ir_write  = mem_ready && rst;
        pc_write  = mem_ready && rst;
      end
      S_DECODE: begin
        alu_src_b  = 2'd3;
        instr_done = dec_bad && !ILLEGAL_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEMRD: mem_read = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      S_RWB: begin
        reg_dst    = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = 2'd3;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'd1;
        pc_src     = 2'd1;
        instr_done = 1'b1;
        branch_eq  = (opcode == 6'b000100);
        branch_ne  = (opcode == 6'b000101);
        branch_gtz = (opcode == 6'b000111);
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_src     = 2'd3;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: hand-written vector table, directed corner
// sequences and random instruction streams against an instruction-level trace model.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

  localparam int NDUT = 3;  // 0: defaults, 1: no jal/jr + wait 4, 2: no trap + wait 1
  localparam logic [3:0] ST_FETCH = 4'd0;
  localparam logic [3:0] ST_TRAP  = 4'd14;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BGTZ = 32'h1C200003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch_eq;
    logic       branch_ne;
    logic       branch_gtz;
    logic       instr_done;
  } ctl_t;

  typedef enum int {
    P_FETCH, P_DECODE, P_DEC_NOP, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_EXEC_R, P_RWB, P_EXEC_I, P_IWB, P_BRANCH, P_JUMP, P_JAL, P_JR, P_TRAP
  } phase_e;

  typedef struct {
    phase_e      ph;
    logic [31:0] instr;
    logic        ready;
    logic        ill;
    logic        tmo;
  } step_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        ready;
    ctl_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_v   [NDUT];
  logic [31:0] instr_v [NDUT];
  logic        rdy_v   [NDUT];
  ctl_t        obs     [NDUT];
  logic        ill_o   [NDUT];
  logic        tmo_o   [NDUT];
  logic [3:0]  st_o    [NDUT];

  int checks = 0;
  int errors = 0;
  step_t trace[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic       ir_write, pc_write, mem_read, mem_write, reg_write, alu_src_a;
    logic       branch_eq, branch_ne, branch_gtz, instr_done, illegal, timeout;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0] state_out;
    mips_multicycle_control #(
      .MEM_WAIT_MAX (g == 0 ? 15 : (g == 1 ? 4 : 1)),
      .ENABLE_JAL_JR(g != 1),
      .ILLEGAL_TRAP (g != 2)
    ) u_dut (
      .clk(clk), .rst(rst_v[g]), .instr(instr_v[g]), .mem_ready(rdy_v[g]),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .branch_eq(branch_eq),
      .branch_ne(branch_ne), .branch_gtz(branch_gtz), .instr_done(instr_done),
      .illegal(illegal), .timeout(timeout), .state_out(state_out)
    );
    assign obs[g] = {ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                     branch_eq, branch_ne, branch_gtz, instr_done};
    assign ill_o[g] = illegal;
    assign tmo_o[g] = timeout;
    assign st_o[g]  = state_out;
  end

  function automatic int wmax(int d);
    return (d == 0) ? 15 : ((d == 1) ? 4 : 1);
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Control word each phase must present, straight from the state table.
  function automatic ctl_t exp_ctl(phase_e ph, logic [5:0] op, logic ready);
    ctl_t c = '0;
    case (ph)
      P_FETCH:   begin c.mem_read = 1; c.alu_src_b = 1; c.ir_write = ready; c.pc_write = ready; end
      P_DECODE:  c.alu_src_b = 3;
      P_DEC_NOP: begin c.alu_src_b = 3; c.instr_done = 1; end
      P_MEMADR:  begin c.alu_src_a = 1; c.alu_src_b = 2; end
      P_MEMRD:   c.mem_read = 1;
      P_MEMWB:   begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
      P_MEMWR:   begin c.mem_write = 1; c.instr_done = ready; end
      P_EXEC_R:  begin c.alu_src_a = 1; c.alu_op = 2; end
      P_RWB:     begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
      P_EXEC_I:  begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = 3; end
      P_IWB:     begin c.reg_write = 1; c.instr_done = 1; end
      P_BRANCH:  begin
        c.alu_src_a = 1; c.alu_op = 1; c.pc_src = 1; c.instr_done = 1;
        c.branch_eq = (op == 6'b000100); c.branch_ne = (op == 6'b000101);
        c.branch_gtz = (op == 6'b000111);
      end
      P_JUMP:    begin c.pc_src = 2; c.pc_write = 1; c.instr_done = 1; end
      P_JAL:     begin
        c.pc_src = 2; c.pc_write = 1; c.reg_dst = 2; c.mem_to_reg = 2;
        c.reg_write = 1; c.instr_done = 1;
      end
      P_JR:      begin c.pc_src = 3; c.pc_write = 1; c.instr_done = 1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic void push(phase_e ph, logic [31:0] ins, logic rdy, logic ill, logic tmo);
    step_t s;
    s.ph = ph; s.instr = ins; s.ready = rdy; s.ill = ill; s.tmo = tmo;
    trace.push_back(s);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // w stall cycles then completion; more stalls than the limit end in TRAP.
  function automatic bit wait_phase(int d, phase_e ph, logic [31:0] ins, int w);
    int n = (w > wmax(d)) ? wmax(d) + 1 : w;
    for (int i = 0; i < n; i++) push(ph, ins, 1'b0, 1'b0, 1'b0);
    if (w > wmax(d)) begin
      push(P_TRAP, ins, rnd_bit(), 1'b0, 1'b1);
      return 1'b1;
    end
    push(ph, ins, 1'b1, 1'b0, 1'b0);
    return 1'b0;
  endfunction

  function automatic bit legal_op(logic [5:0] op);
    return op inside {6'b100011, 6'b100000, 6'b100001, 6'b101011, 6'b101000, 6'b101001,
                      6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                      6'b000100, 6'b000101, 6'b000111, 6'b000010, 6'b000011};
  endfunction

  // Appends the expected cycle trace of one instruction; returns 1 if it ends in TRAP.
  function automatic bit build(int d, logic [31:0] ins, int fw, int mw);
    logic [5:0] op    = ins[31:26];
    bit         is_jr = (op == 6'b000000) && (ins[5:0] == 6'b001000);
    bit         bad   = !legal_op(op) || ((op == 6'b000011 || is_jr) && d == 1);
    if (wait_phase(d, P_FETCH, ins, fw)) return 1'b1;
    if (bad) begin
      if (d == 2) begin
        push(P_DEC_NOP, ins, rnd_bit(), 1'b0, 1'b0);
        return 1'b0;
      end
      push(P_DECODE, ins, rnd_bit(), 1'b0, 1'b0);
      push(P_TRAP, ins, rnd_bit(), 1'b1, 1'b0);
      return 1'b1;
    end
    push(P_DECODE, ins, rnd_bit(), 1'b0, 1'b0);
    if (op[5]) begin
      push(P_MEMADR, ins, rnd_bit(), 1'b0, 1'b0);
      if (op[3]) return wait_phase(d, P_MEMWR, ins, mw);
      if (wait_phase(d, P_MEMRD, ins, mw)) return 1'b1;
      push(P_MEMWB, ins, rnd_bit(), 1'b0, 1'b0);
    end else if (is_jr) begin
      push(P_JR, ins, rnd_bit(), 1'b0, 1'b0);
    end else if (op == 6'b000000) begin
      push(P_EXEC_R, ins, rnd_bit(), 1'b0, 1'b0);
      push(P_RWB, ins, rnd_bit(), 1'b0, 1'b0);
    end else if (op[3]) begin
      push(P_EXEC_I, ins, rnd_bit(), 1'b0, 1'b0);
      push(P_IWB, ins, rnd_bit(), 1'b0, 1'b0);
    end else if (op[2]) begin
      push(P_BRANCH, ins, rnd_bit(), 1'b0, 1'b0);
    end else if (op[0]) begin
      push(P_JAL, ins, rnd_bit(), 1'b0, 1'b0);
    end else begin
      push(P_JUMP, ins, rnd_bit(), 1'b0, 1'b0);
    end
    return 1'b0;
  endfunction

  function automatic void hold_trap();
    step_t s = trace[$];
    s.ready = ~s.ready;
    trace.push_back(s);
  endfunction

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_trace(int d, string tag);
    foreach (trace[i]) begin
      string nm = $sformatf("%s d%0d step%0d %s", tag, d, i, trace[i].ph.name());
      instr_v[d] = trace[i].instr;
      rdy_v[d]   = trace[i].ready;
      @(negedge clk);
      check({nm, " ctl"}, 64'(obs[d]), 64'(exp_ctl(trace[i].ph, trace[i].instr[31:26], trace[i].ready)));
      check({nm, " flags"}, {62'd0, ill_o[d], tmo_o[d]}, {62'd0, trace[i].ill, trace[i].tmo});
      if (trace[i].ph == P_FETCH) check({nm, " state"}, 64'(st_o[d]), 64'(ST_FETCH));
      if (trace[i].ph == P_TRAP)  check({nm, " state"}, 64'(st_o[d]), 64'(ST_TRAP));
      @(posedge clk); #1;
    end
    trace.delete();
  endtask

  task automatic do_reset(int d);
    ctl_t rst_ctl = ctl_t'{mem_read: 1'b1, alu_src_b: 2'd1, default: '0};
    rst_v[d] = 1'b0;
    rdy_v[d] = 1'b1;
    @(negedge clk);
    check($sformatf("reset d%0d ctl", d), 64'(obs[d]), 64'(rst_ctl));
    check($sformatf("reset d%0d flags", d), {62'd0, ill_o[d], tmo_o[d]}, 64'd0);
    check($sformatf("reset d%0d state", d), 64'(st_o[d]), 64'(ST_FETCH));
    @(posedge clk); #1;
    rst_v[d] = 1'b1;
  endtask

  function automatic void tv(string n, logic [31:0] i, logic r, ctl_t e);
    vec_t v;
    v.name = n; v.instr = i; v.ready = r; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [17] = '{6'b100011, 6'b100000, 6'b100001, 6'b101011, 6'b101000,
                              6'b101001, 6'b000000, 6'b000000, 6'b001000, 6'b001100,
                              6'b001101, 6'b001010, 6'b000100, 6'b000101, 6'b000111,
                              6'b000010, 6'b000011};
    logic [31:0] ins = $urandom;
    int          k   = $urandom_range(0, 18);
    if (k < 17) begin
      ins[31:26] = ops[k];
      if (k == 6) ins[5:0] = 6'b001000;
      else if (ins[31:26] == 6'b000000 && ins[5:0] == 6'b001000) ins[0] = 1'b1;
    end else begin
      do ins[31:26] = 6'($urandom_range(0, 63)); while (legal_op(ins[31:26]));
    end
    return ins;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit trapped;
    tv("add fetch",   I_ADD,  1, ctl_t'{ir_write: 1, pc_write: 1, mem_read: 1, alu_src_b: 1, default: '0});
    tv("add decode",  I_ADD,  1, ctl_t'{alu_src_b: 3, default: '0});
    tv("add exec_r",  I_ADD,  1, ctl_t'{alu_src_a: 1, alu_op: 2, default: '0});
    tv("add rwb",     I_ADD,  1, ctl_t'{reg_dst: 1, reg_write: 1, instr_done: 1, default: '0});
    tv("lw fetch",    I_LW,   1, ctl_t'{ir_write: 1, pc_write: 1, mem_read: 1, alu_src_b: 1, default: '0});
    tv("lw decode",   I_LW,   1, ctl_t'{alu_src_b: 3, default: '0});
    tv("lw memadr",   I_LW,   1, ctl_t'{alu_src_a: 1, alu_src_b: 2, default: '0});
    tv("lw memrd w1", I_LW,   0, ctl_t'{mem_read: 1, default: '0});
    tv("lw memrd w2", I_LW,   0, ctl_t'{mem_read: 1, default: '0});
    tv("lw memrd w3", I_LW,   0, ctl_t'{mem_read: 1, default: '0});
    tv("lw memrd rdy", I_LW,  1, ctl_t'{mem_read: 1, default: '0});
    tv("lw memwb",    I_LW,   1, ctl_t'{mem_to_reg: 1, reg_write: 1, instr_done: 1, default: '0});
    tv("sw fetch",    I_SW,   1, ctl_t'{ir_write: 1, pc_write: 1, mem_read: 1, alu_src_b: 1, default: '0});
    tv("sw decode",   I_SW,   0, ctl_t'{alu_src_b: 3, default: '0});
    tv("sw memadr",   I_SW,   0, ctl_t'{alu_src_a: 1, alu_src_b: 2, default: '0});
    tv("sw memwr w1", I_SW,   0, ctl_t'{mem_write: 1, default: '0});
    tv("sw memwr rdy", I_SW,  1, ctl_t'{mem_write: 1, instr_done: 1, default: '0});
    tv("beq fetch",   I_BEQ,  1, ctl_t'{ir_write: 1, pc_write: 1, mem_read: 1, alu_src_b: 1, default: '0});
    tv("beq decode",  I_BEQ,  1, ctl_t'{alu_src_b: 3, default: '0});
    tv("beq branch",  I_BEQ,  1, ctl_t'{alu_src_a: 1, alu_op: 1, pc_src: 1, branch_eq: 1, instr_done: 1, default: '0});
    tv("bgtz fetch",  I_BGTZ, 1, ctl_t'{ir_write: 1, pc_write: 1, mem_read: 1, alu_src_b: 1, default: '0});
    tv("bgtz decode", I_BGTZ, 1, ctl_t'{alu_src_b: 3, default: '0});
    tv("bgtz branch", I_BGTZ, 1, ctl_t'{alu_src_a: 1, alu_op: 1, pc_src: 1, branch_gtz: 1, instr_done: 1, default: '0});
    tv("fetch stall", I_ADD,  0, ctl_t'{mem_read: 1, alu_src_b: 1, default: '0});

    for (int d = 0; d < NDUT; d++) begin
      rst_v[d] = 1'b0; rdy_v[d] = 1'b0; instr_v[d] = '0;
    end
    @(posedge clk); #1;

    do_reset(0);
    foreach (tbl[i]) begin
      instr_v[0] = tbl[i].instr;
      rdy_v[0]   = tbl[i].ready;
      @(negedge clk);
      check({"table ", tbl[i].name}, 64'(obs[0]), 64'(tbl[i].exp));
      @(posedge clk); #1;
    end

    // FETCH timeout: 16 stalled cycles trap, 15 do not.
    do_reset(0);
    trapped = build(0, I_ADD, 16, 0);
    check("fetch timeout traps", 64'(trapped), 64'd1);
    hold_trap();
    run_trace(0, "fetch_to");
    do_reset(0);
    void'(build(0, I_ADD, 15, 0));
    run_trace(0, "fetch_15");

    // MEMRD timeout on the short-limit instance.
    do_reset(1);
    void'(build(1, I_LW, 0, 5));
    hold_trap();
    run_trace(1, "memrd_to");

    // Illegal opcode: trap vs. treat-as-NOP.
    do_reset(0);
    void'(build(0, I_ILL, 0, 0));
    hold_trap();
    run_trace(0, "ill_trap");
    do_reset(2);
    void'(build(2, I_ILL, 0, 0));
    void'(build(2, I_ADD, 1, 0));
    run_trace(2, "ill_nop");

    // jal / jr enabled and disabled.
    do_reset(0);
    void'(build(0, I_JAL, 0, 0));
    void'(build(0, I_JR, 0, 0));
    run_trace(0, "jal_jr");
    do_reset(1);
    void'(build(1, I_JAL, 0, 0));
    hold_trap();
    run_trace(1, "jal_off");
    do_reset(1);
    void'(build(1, I_JR, 0, 0));
    hold_trap();
    run_trace(1, "jr_off");

    // Asynchronous reset in the middle of a store.
    do_reset(0);
    void'(build(0, I_SW, 0, 3));
    trace = trace[0:2];
    run_trace(0, "sw_abort");
    rdy_v[0] = 1'b0;
    #1;
    check("memwr before reset", 64'(obs[0].mem_write), 64'd1);
    rst_v[0] = 1'b0;
    #1;
    check("memwr drops on reset", 64'(obs[0].mem_write), 64'd0);
    check("state fetch in reset", 64'(st_o[0]), 64'(ST_FETCH));
    @(posedge clk); #1;
    rst_v[0] = 1'b1;

    // Random instruction streams on every configuration.
    for (int d = 0; d < NDUT; d++) begin
      do_reset(d);
      for (int n = 0; n < 40; n++) begin
        int fw = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, wmax(d) + 2);
        int mw = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, wmax(d) + 2);
        trapped = build(d, rand_instr(), fw, mw);
        if (trapped) hold_trap();
        run_trace(d, "rand");
        if (trapped) do_reset(d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
